// File: rtl/cpu_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_irq_pkg
// Description : Shared types and constants for the CPU interrupt arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_irq_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } irq_state_t;

    localparam logic [15:0] c_VEC_BASE_DEFAULT = 16'hFFE0;

endpackage
`default_nettype wire

// File: rtl/cpu_irq_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_irq_arbiter_if
// Description : Core-side request/grant bundle of the interrupt arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_irq_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 4
);
    logic               ce;
    logic [NUM_SRC-1:0] src;
    logic [NUM_SRC-1:0] src_en;
    logic               irq_disable;
    logic               poll;
    logic               vec_ack;
    logic               ovf_clr;
    logic               int_req;
    logic [ID_W-1:0]    int_id;
    logic               int_nmi;
    logic [15:0]        int_vec;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] ovf;

    modport master (
        output ce, src, src_en, irq_disable, poll, vec_ack, ovf_clr,
        input  int_req, int_id, int_nmi, int_vec, pending, ovf
    );

    modport slave (
        input  ce, src, src_en, irq_disable, poll, vec_ack, ovf_clr,
        output int_req, int_id, int_nmi, int_vec, pending, ovf
    );
endinterface
`default_nettype wire

// File: rtl/irq_edge_latch.sv
`default_nettype none
// ============================================================================
// Module      : irq_edge_latch
// Description : Per-source rising-edge detector with sticky pending/overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_edge_latch (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_ce,
    input  wire logic i_src,
    input  wire logic i_en,
    input  wire logic i_clr,
    input  wire logic i_ovf_clr,
    output logic      o_pending,
    output logic      o_ovf
);
    logic r_prev;
    logic r_latch;
    logic r_ovf;
    logic w_rise;

    assign w_rise    = i_src & ~r_prev;
    assign o_pending = r_latch;
    assign o_ovf     = r_ovf;

    // A new edge outranks an ack clear so a request arriving during the
    // vector fetch is never dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev  <= 1'b0;
            r_latch <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (i_ce) begin
            r_prev <= i_src;
            if (w_rise && i_en)
                r_latch <= 1'b1;
            else if (i_clr)
                r_latch <= 1'b0;
            if (w_rise && r_latch && !i_clr)
                r_ovf <= 1'b1;
            else if (i_ovf_clr)
                r_ovf <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/cpu_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cpu_irq_arbiter
// Description : Prioritised N-source interrupt front-end for a 6502-class core.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_irq_arbiter
    import cpu_irq_pkg::*;
#(
    parameter int                 NUM_SRC   = 4,
    parameter int                 ID_W      = 4,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = NUM_SRC'(1),
    parameter logic [NUM_SRC-1:0] NMI_MASK  = NUM_SRC'(1),
    parameter logic [15:0]        VEC_BASE  = c_VEC_BASE_DEFAULT
) (
    input  wire logic         clk,
    input  wire logic         reset,
    cpu_irq_arbiter_if.slave  bus
);
    irq_state_t         r_state;
    logic               r_int_req;
    logic [ID_W-1:0]    r_int_id;
    logic               r_int_nmi;
    logic [NUM_SRC-1:0] w_pending;
    logic [NUM_SRC-1:0] w_ovf;
    logic [NUM_SRC-1:0] w_elig;
    logic [ID_W-1:0]    w_winner;
    logic               w_win_nmi;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            if (EDGE_MASK[i]) begin : g_edge
                logic w_ack_clr;
                assign w_ack_clr = (r_state == HELD) & bus.vec_ack & (r_int_id == ID_W'(i));

                irq_edge_latch u_latch (
                    .clk       (clk),
                    .reset     (reset),
                    .i_ce      (bus.ce),
                    .i_src     (bus.src[i]),
                    .i_en      (bus.src_en[i]),
                    .i_clr     (w_ack_clr),
                    .i_ovf_clr (bus.ovf_clr),
                    .o_pending (w_pending[i]),
                    .o_ovf     (w_ovf[i])
                );
            end else begin : g_level
                logic r_lvl;
                always_ff @(posedge clk) begin
                    if (reset)
                        r_lvl <= 1'b0;
                    else if (bus.ce)
                        r_lvl <= bus.src[i] & bus.src_en[i];
                end
                assign w_pending[i] = r_lvl;
                assign w_ovf[i]     = 1'b0;
            end
        end
    endgenerate

    assign w_elig = w_pending & (NMI_MASK | {NUM_SRC{~bus.irq_disable}});

    // Scanning downward leaves the lowest eligible index as the winner.
    always_comb begin
        w_winner  = '0;
        w_win_nmi = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_winner  = ID_W'(i);
                w_win_nmi = NMI_MASK[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_int_req <= 1'b0;
            r_int_id  <= '0;
            r_int_nmi <= 1'b0;
        end else if (bus.ce) begin
            case (r_state)
                IDLE: begin
                    if (bus.poll && (|w_elig)) begin
                        r_int_id  <= w_winner;
                        r_int_nmi <= w_win_nmi;
                        r_int_req <= 1'b1;
                        r_state   <= HELD;
                    end
                end
                HELD: begin
                    if (bus.vec_ack) begin
                        r_int_req <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.int_req = r_int_req;
    assign bus.int_id  = r_int_id;
    assign bus.int_nmi = r_int_nmi;
    assign bus.int_vec = VEC_BASE + 16'({r_int_id, 1'b0});
    assign bus.pending = w_pending;
    assign bus.ovf     = w_ovf;
endmodule
`default_nettype wire

// File: tb/tb_cpu_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_irq_arbiter
// Description : Directed and random checks of cpu_irq_arbiter against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_irq_arbiter;
    localparam int          N    = 4;
    localparam int          IDW  = 4;
    localparam logic [N-1:0] EDGE = 4'b0001;
    localparam logic [N-1:0] NMI  = 4'b0001;
    localparam logic [15:0] VB   = 16'hFFE0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_irq_arbiter_if #(.NUM_SRC(N), .ID_W(IDW)) bus ();

    cpu_irq_arbiter #(
        .NUM_SRC(N), .ID_W(IDW), .EDGE_MASK(EDGE), .NMI_MASK(NMI), .VEC_BASE(VB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain per-source state, updated from the rules.
    bit m_prev [N];
    bit m_pend [N];
    bit m_ovf  [N];
    bit m_req;
    int m_id;
    bit m_nmi;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] pack(bit v [N]);
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic model_step();
        bit ack;
        bit rise;
        bit clr;
        int win;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_prev[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
            end
            m_req = 0; m_id = 0; m_nmi = 0;
        end else if (bus.ce) begin
            ack = m_req && bus.vec_ack;
            win = -1;
            for (int i = 0; i < N; i++)
                if (win < 0 && m_pend[i] && (NMI[i] || !bus.irq_disable)) win = i;
            for (int i = 0; i < N; i++) begin
                if (EDGE[i]) begin
                    rise = bus.src[i] && !m_prev[i];
                    clr  = ack && (m_id == i);
                    if (rise && m_pend[i] && !clr) m_ovf[i] = 1;
                    else if (bus.ovf_clr)          m_ovf[i] = 0;
                    if (rise && bus.src_en[i]) m_pend[i] = 1;
                    else if (clr)              m_pend[i] = 0;
                end else begin
                    m_pend[i] = bus.src[i] && bus.src_en[i];
                end
                m_prev[i] = bus.src[i];
            end
            if (!m_req && bus.poll && win >= 0) begin
                m_req = 1; m_id = win; m_nmi = NMI[win];
            end else if (ack) begin
                m_req = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("int_req", 32'(bus.int_req), 32'(m_req));
        chk("int_id",  32'(bus.int_id),  32'(m_id));
        chk("int_nmi", 32'(bus.int_nmi), 32'(m_nmi));
        chk("int_vec", 32'(bus.int_vec), 32'(VB) + 32'(2 * m_id));
        chk("pending", 32'(bus.pending), 32'(pack(m_pend)));
        chk("ovf",     32'(bus.ovf),     32'(pack(m_ovf)));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_in(logic [N-1:0] s, logic dis, logic p, logic a, logic oc);
        bus.ce = 1'b1; bus.src_en = '1;
        bus.src = s; bus.irq_disable = dis; bus.poll = p; bus.vec_ack = a; bus.ovf_clr = oc;
    endtask

    task automatic do_reset();
        set_in('0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1; cycle(); cycle(); reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_in('0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        chk("rst_req", 32'(bus.int_req), 32'd0);
        chk("rst_vec", 32'(bus.int_vec), 32'hFFE0);

        // Edge NMI with I flag set
        set_in(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
        set_in(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0); cycle();
        chk("t1_req", 32'(bus.int_req), 32'd1);
        chk("t1_vec", 32'(bus.int_vec), 32'hFFE0);
        chk("t1_nmi", 32'(bus.int_nmi), 32'd1);
        set_in(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0); cycle();
        chk("t1_ack_req", 32'(bus.int_req), 32'd0);
        chk("t1_pend0",   32'(bus.pending[0]), 32'd0);

        // Level source masked, then unmasked
        set_in(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
        set_in(4'b0100, 1'b1, 1'b1, 1'b0, 1'b0); cycle();
        chk("t2_masked", 32'(bus.int_req), 32'd0);
        set_in(4'b0100, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
        chk("t2_id",  32'(bus.int_id),  32'd2);
        chk("t2_vec", 32'(bus.int_vec), 32'hFFE4);
        set_in(4'b0100, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
        chk("t2_lvl_pend", 32'(bus.pending[2]), 32'd1);
        set_in(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
        chk("t2_lvl_drop", 32'(bus.pending[2]), 32'd0);

        // Priority and freeze while held
        set_in(4'b1010, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
        set_in(4'b1010, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
        chk("t3_id1", 32'(bus.int_id), 32'd1);
        set_in(4'b1011, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
        chk("t3_frozen", 32'(bus.int_id), 32'd1);
        set_in(4'b1010, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
        set_in(4'b1010, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
        chk("t3_id0", 32'(bus.int_id), 32'd0);
        set_in(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
        do_reset();

        // Overflow, edge during ack, overflow clear
        set_in(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
        set_in(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
        set_in(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
        chk("t4_ovf", 32'(bus.ovf[0]), 32'd1);
        set_in(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
        set_in(4'b0001, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
        chk("t4_keep_pend", 32'(bus.pending[0]), 32'd1);
        set_in(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1); cycle();
        chk("t4_ovf_clr", 32'(bus.ovf), 32'd0);
        do_reset();

        // Grant survives source drop
        set_in(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
        set_in(4'b0100, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
        set_in(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0); cycle(); cycle();
        chk("t5_vec_held", 32'(bus.int_vec), 32'hFFE4);
        chk("t5_req_held", 32'(bus.int_req), 32'd1);

        // Reset in HELD, then ce=0 freeze
        reset = 1'b1; cycle(); reset = 1'b0;
        chk("t6_req",  32'(bus.int_req), 32'd0);
        chk("t6_pend", 32'(bus.pending), 32'd0);
        chk("t6_vec",  32'(bus.int_vec), 32'hFFE0);
        for (int k = 0; k < 5; k++) begin
            set_in((k % 2 == 0) ? 4'b1111 : 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
            bus.ce = 1'b0;
            cycle();
        end
        chk("t6_frozen_pend", 32'(bus.pending), 32'd0);
        chk("t6_frozen_req",  32'(bus.int_req), 32'd0);

        // Randomised traffic
        for (int k = 0; k < 3000; k++) begin
            bus.ce          = ($urandom_range(0, 9) < 8);
            bus.src         = N'($urandom);
            bus.src_en      = ($urandom_range(0, 9) < 8) ? '1 : N'($urandom);
            bus.irq_disable = $urandom_range(0, 1) == 1;
            bus.poll        = ($urandom_range(0, 9) < 3);
            bus.vec_ack     = ($urandom_range(0, 9) < 3);
            bus.ovf_clr     = ($urandom_range(0, 19) == 0);
            reset           = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cpu_irq_arbiter.md
Name: cpu_irq_arbiter

Overview:
- Parametrised interrupt front-end for the 6502-class core; replaces the hard-wired NMI/IRQ/reset vector logic with N prioritised sources.
- Each source is configurable as edge or level triggered and as maskable or non-maskable.
- Samples requests on each ce cycle and latches a winner at the core's instruction-boundary poll.
- Holds the winner stable through the vector fetch and supplies the vector address.

Parameters:
- NUM_SRC, 4, number of interrupt sources (2..16); index 0 is highest priority.
- ID_W, 4, width of the source id; must satisfy 2**ID_W >= NUM_SRC.
- EDGE_MASK, 4'b0001, bit i=1: source i is rising-edge triggered; bit i=0: level triggered.
- NMI_MASK, 4'b0001, bit i=1: source i ignores irq_disable.
- VEC_BASE, 16'hFFE0, vector low-byte address of source 0; source i uses VEC_BASE + 2*i.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ce  in  1  clock enable; all state updates only when ce=1
- src  in  NUM_SRC  raw request lines, active-high
- src_en  in  NUM_SRC  per-source enable
- irq_disable  in  1  CPU I flag; masks sources with NMI_MASK bit 0
- poll  in  1  instruction-boundary sample strobe from the core
- vec_ack  in  1  vector high byte fetched; ends the interrupt sequence
- ovf_clr  in  1  clears all overflow flags
- int_req  out  1  interrupt granted, pending service
- int_id  out  ID_W  latched winning source
- int_nmi  out  1  the latched winner is non-maskable
- int_vec  out  16  VEC_BASE + {int_id,1'b0}, combinational from the int_id register
- pending  out  NUM_SRC  current pending vector
- ovf  out  NUM_SRC  sticky: an edge arrived while that source was already pending

Behaviour:
- Reset (clk edge with reset=1, regardless of ce) clears all of the following:
  - int_req, int_id, int_nmi, pending edge latches, ovf, previous-sample register; FSM goes to IDLE.
  - int_vec therefore reads VEC_BASE.
  - Because prev resets to 0, a source held high through reset produces one edge on the first ce cycle after reset.
- Edge detection: prev <= src on every ce cycle. rise[i] = src[i] & ~prev[i] & EDGE_MASK[i].
- Edge pending latch: set on rise & src_en; cleared by an ack of that id. Set wins over clear in the same cycle, so no edge is lost.
- ovf[i] is set when rise[i] occurs while the latch is already 1 and it is not being cleared that cycle. ovf_clr clears ovf; a set in the same cycle wins.
- Level pending: pending[i] = src[i] & src_en[i], registered each ce cycle; no latch and no clear by ack.
- Eligibility: elig[i] = pending[i] & (NMI_MASK[i] | ~irq_disable). The winner is the lowest eligible index.
- FSM IDLE:
  - On poll & ce & |elig: int_id <= winner, int_nmi <= NMI_MASK[winner], int_req <= 1, go to HELD.
  - On poll with no eligible source: stay in IDLE.
- FSM HELD:
  - int_id and int_vec are frozen; poll is ignored; new requests only accumulate in pending.
  - On vec_ack & ce: int_req <= 0, clear the edge latch of int_id (if it is an edge source), go to IDLE. int_id keeps its value.
- A source that deasserts or is disabled while in HELD does not cancel the grant; the vector is still delivered (6502 semantics).
- vec_ack in IDLE is ignored. poll and vec_ack together in HELD: ack is processed, poll is ignored.
- Simultaneous poll and vec_ack in IDLE: poll is processed.
- Latency:
  - A request sampled at cycle n is visible in pending at n+1.
  - The earliest grant is at the poll in cycle n+1, with int_req high at n+2.
- ce=0 freezes all registers, including prev. Edges shorter than one ce period may be missed; this is documented and not flagged.

Decomposition:
- Package cpu_irq_pkg holds the FSM state encoding (IDLE=0, HELD=1) and a default vector-base localparam.
- One sub-module, irq_edge_latch: per-source prev/latch/ovf with set-wins semantics, generated NUM_SRC times. Level sources bypass it.
- The priority encoder is an inline for-loop from high index down to 0.

Test Plan:
- Edge NMI (src[0], NMI_MASK[0]=1) pulse with irq_disable=1, then poll → int_req=1, int_id=0, int_vec=16'hFFE0, int_nmi=1. vec_ack → int_req=0, pending[0]=0.
- Level src[2] high with irq_disable=1, poll → no grant. Drop irq_disable, poll → int_id=2, int_vec=16'hFFE4. After vec_ack, pending[2] stays 1 until src[2]=0.
- src[1] and src[3] both eligible, poll → int_id=1. src[0] edge while HELD → int_id stays 1. After vec_ack, next poll → int_id=0.
- Two rising edges on src[0] without ack → ovf[0]=1. Edge coinciding with vec_ack of id 0 → pending[0] remains 1. ovf_clr → ovf=0.
- Grant id 2, then src[2] drops before vec_ack → int_vec stays 16'hFFE4 until ack.
- Reset asserted in HELD → next cycle int_req=0, pending=0, int_vec=16'hFFE0. With ce=0 held for 5 cycles and a src toggle, no state changes.
